// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the
// clock/baud/time conversion helpers used by both the rx and tx sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } tx_state_t;

  // System clocks spent on one line bit.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Converts a duration in ns to a whole number of system clocks.
  function automatic int unsigned ns_to_cycles(input int unsigned ns,
                                               input int unsigned clk_hz);
    return ns / (32'd1_000_000_000 / clk_hz);
  endfunction

  function automatic int unsigned max_u(input int unsigned a,
                                        input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Parallel-frame handshake plus serial line between game logic (master)
// and the frame transmitter (slave).
interface uart_frame_tx_if #(
  parameter int unsigned FRAME_BITS = 162
);

  logic [FRAME_BITS-1:0] data_in;
  logic                  valid_in;
  logic                  ready_out;
  logic                  tx;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  tx
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output tx
  );

endinterface

// File: rtl/uart_baud_timer.sv
// Loadable down-counter. done_o is high while the count sits at zero, so a
// load of N-1 gives a done indication after exactly N cycles. Used for both
// line-bit timing and the post-frame gap.
module uart_baud_timer #(
  parameter int unsigned W = 18
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: a load takes priority, otherwise count down and rest at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register with synchronous reset to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/uart_frame_tx.sv
// Frame transmitter: latches a FRAME_BITS-wide frame, sends it as back-to-back
// 8N1 packets (LSB first, zero-padded past the frame end), then holds the line
// idle for the gap the peer receiver uses to delimit frames.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned PKT_LEN    = 8,
  parameter int unsigned FRAME_BITS = 162,
  parameter int unsigned WAIT_TIME  = 2_000_000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  uart_frame_tx_if.slave   bus
);

  localparam int unsigned CLK_PER_BIT = clks_per_bit(CLK_HZ, BAUD_RATE);
  localparam int unsigned NUM_PKTS    = (FRAME_BITS + PKT_LEN - 1) / PKT_LEN;
  localparam int unsigned GAP_COUNT   = ns_to_cycles(WAIT_TIME, CLK_HZ);
  localparam int unsigned TMR_W       = $clog2(max_u(CLK_PER_BIT, GAP_COUNT));
  localparam int unsigned PKT_W       = $clog2(NUM_PKTS + 1);
  localparam int unsigned BIT_W       = $clog2(PKT_LEN + 1);

  localparam logic [TMR_W-1:0] BIT_LOAD  = TMR_W'(CLK_PER_BIT - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_COUNT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(PKT_LEN - 1);
  localparam logic [PKT_W-1:0] PKTS_DONE = PKT_W'(NUM_PKTS);

  tx_state_t             state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [PKT_W-1:0]      pkt_q;
  logic [BIT_W-1:0]      bit_q;
  logic                  tx_q;
  logic                  ready_q;

  logic                  accept;
  logic                  tmr_load;
  logic [TMR_W-1:0]      tmr_val;
  logic                  tmr_done;

  assign accept = bus.valid_in && ready_q;

  // Reload the shared timer whenever a timed state is entered: one bit time
  // for start/data/stop, the gap length only after the final stop bit.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = BIT_LOAD;
    case (state_q)
      IDLE:  tmr_load = accept;
      START: tmr_load = tmr_done;
      DATA:  tmr_load = tmr_done;
      STOP: begin
        tmr_load = tmr_done;
        if (pkt_q == PKTS_DONE) begin
          tmr_val = GAP_LOAD;
        end
      end
      default: tmr_load = 1'b0;
    endcase
  end

  uart_baud_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Transmit FSM with registered line and ready outputs; the shift register
  // zero-fills so the tail of the last packet is padded with zeros.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      shift_q <= '0;
      pkt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= bus.data_in;
            pkt_q   <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (tmr_done) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tmr_done) begin
            if (bit_q == LAST_BIT) begin
              tx_q    <= 1'b1;
              pkt_q   <= pkt_q + 1'b1;
              state_q <= STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tmr_done) begin
            if (pkt_q == PKTS_DONE) begin
              tx_q    <= 1'b1;
              state_q <= GAP;
            end else begin
              tx_q    <= 1'b0;
              state_q <= START;
            end
          end
        end
        GAP: begin
          if (tmr_done) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx        = tx_q;
  assign bus.ready_out = ready_q;

endmodule
